lcd_refresh_ctrl: RTL and testbench
===================================

# lcd_refresh_ctrl

Read-side consumer of the 32-byte LCD character RAM. After power-up it initialises an HD44780-compatible 16x2 character LCD in 8-bit write-only mode, then loops forever, fetching each character from the RAM read port and writing it to the panel. It sits between the character RAM (fed by game logic) and the board LCD pins.

## Interface
- `POWERUP_CYC`, 750000: idle cycles after reset before the first command (15 ms at 50 MHz).
- `SETUP_CYC`, 2: cycles from `lcd_rs`/`lcd_data` valid to `lcd_en` rise; minimum 1.
- `EN_PULSE_CYC`, 12: cycles `lcd_en` stays high; minimum 1.
- `WAIT_CYC`, 2500: cycles after `lcd_en` falls, for normal commands and characters; minimum 1.
- `CLEAR_WAIT_CYC`, 82000: cycles after `lcd_en` falls, for the clear command only.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `raddr` out 5: character RAM read address.
- `rdata` in 8: character RAM read data; combinational from `raddr`.
- `lcd_data` out 8: LCD DB7..DB0.
- `lcd_rs` out 1: 0 = command, 1 = character data.
- `lcd_rw` out 1: tied 0 (write only).
- `lcd_en` out 1: LCD enable strobe.
- `lcd_on` out 1: panel power enable.
- `frame_done` out 1: one-cycle pulse after the last character of each frame.

## Operation
- Reset values: `raddr`=0, `lcd_data`=0x00, `lcd_rs`=0, `lcd_rw`=0, `lcd_en`=0, `lcd_on`=0, `frame_done`=0.
- `lcd_on` goes to 1 on the first clock after reset release and stays 1.
- States, in order:
  - PWRUP: wait `POWERUP_CYC` cycles.
  - INIT: four commands, 0x38 (function set), DISPCTL (0x0C), 0x01 (clear), 0x06 (entry mode).
  - LINE1: command 0x80, then characters at `raddr` 0..15.
  - LINE2: command 0xC0, then characters at `raddr` 16..31.
  - DONE: `frame_done` pulses for one cycle, then the next cycle starts LINE1. DONE takes no extra cycle.
- INIT runs once per reset. LINE1→LINE2→DONE repeats forever.
- Command slot (`lcd_rs`=0):
  - Slot cycle 0 registers `lcd_data`.
  - `lcd_en`=1 from cycle `SETUP_CYC` for `EN_PULSE_CYC` cycles.
  - Then `WAIT_CYC` low cycles, or `CLEAR_WAIT_CYC` for 0x01.
  - Slot length = SETUP+EN+WAIT.
- Character slot (`lcd_rs`=1):
  - A prefetch cycle drives `raddr`.
  - The next cycle registers `rdata` into `lcd_data` and starts the command-slot timing.
  - Length = 1+SETUP+EN+WAIT.
- `lcd_rs`, `lcd_data` and `raddr` are stable throughout the `lcd_en`-high window and the hold window.
- `raddr` keeps its last value during command slots.
- RAM writes are not synchronised. A byte written after its prefetch cycle appears in the next frame; no tearing guarantee.
- Reset mid-operation: all outputs take their reset values immediately (`lcd_en` drops asynchronously). Operation restarts at PWRUP, including full INIT.
- Counter widths are sized by `$clog2` of the largest parameter. No counter wraps.

## Timing
- First `lcd_en` rise: `POWERUP_CYC`+`SETUP_CYC` cycles after reset release (counted from the first rising edge with `rst_n`=1).
- INIT length = 4·(SETUP+EN) + 3·WAIT + CLEAR_WAIT.
- Frame period = 2·(SETUP+EN+WAIT) + 32·(1+SETUP+EN+WAIT) cycles between `frame_done` pulses.
- All outputs are registered. No combinational path from `rdata` to any output.

## Configuration
- `LCD_CURSOR_BLINK_EN` defined:
  - DISPCTL = 0x0F (display, cursor and blink on).
  - After the last character of LINE2, an extra command 0x8F parks the cursor at line 1, column 15.
  - That command adds SETUP+EN+WAIT cycles before DONE.
- Undefined: DISPCTL = 0x0C, no park command.

## Structure
- Package `lcd_pkg`:
  - Command constants: `LCD_CMD_FUNC`=0x38, `LCD_CMD_DISP_ON`=0x0C, `LCD_CMD_DISP_BLINK`=0x0F, `LCD_CMD_CLEAR`=0x01, `LCD_CMD_ENTRY`=0x06, `LCD_CMD_LINE1`=0x80, `LCD_CMD_LINE2`=0xC0.
  - Top-level state enum.
  - `LCD_COLS`=16, `LCD_ROWS`=2.
- Sub-module `lcd_write_strobe`: one-byte timing engine with `start`, `rs`, `data`, `long_wait` inputs and a `done` pulse. It owns the `lcd_en` setup/pulse/hold counter. The top FSM sequences bytes only.

## Test plan
Bench parameters: POWERUP=10, SETUP=1, EN=2, WAIT=3, CLEAR_WAIT=8; macro off.
- Reset release:
  - First `lcd_en` rise 11 cycles later, with `lcd_data`=0x38, `lcd_rs`=0.
  - Next three rises carry 0x0C, 0x01, 0x06.
  - The gap after the 0x01 fall is 8 cycles.
- RAM holds "Score:" + spaces:
  - First frame writes 0x80, then 0x53 0x63 0x6F 0x72 0x65 0x3A and ten 0x20 with `lcd_rs`=1.
  - Then 0xC0 and sixteen 0x20.
- Free run: `frame_done` pulses are exactly 236 cycles apart; `raddr` sequence is 0..31 per frame.
- Write RAM[0x10]="7" mid-LINE1: 0x37 appears at LINE2 column 0 in the same frame.
- Assert `rst_n`=0 while `lcd_en`=1: `lcd_en` drops without waiting for a clock; after release the full INIT repeats (0x38 first).
- Macro defined:
  - Second INIT byte is 0x0F.
  - 0x8F is written after character 31.
  - `frame_done` period is 242 cycles.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and init-command table for the LCD refresh path.
// Optional feature macro: LCD_CURSOR_BLINK_EN (blinking cursor parked at line 1, column 15).
package lcd_pkg;

   localparam logic [7:0] LCD_CMD_FUNC       = 8'h38;
   localparam logic [7:0] LCD_CMD_DISP_ON    = 8'h0C;
   localparam logic [7:0] LCD_CMD_DISP_BLINK = 8'h0F;
   localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
   localparam logic [7:0] LCD_CMD_ENTRY      = 8'h06;
   localparam logic [7:0] LCD_CMD_LINE1      = 8'h80;
   localparam logic [7:0] LCD_CMD_LINE2      = 8'hC0;

   localparam int LCD_COLS = 16;
   localparam int LCD_ROWS = 2;

   // DDRAM address of the last column on line 1
   localparam logic [7:0] LCD_CMD_PARK = LCD_CMD_LINE1 | 8'(LCD_COLS - 1);

`ifdef LCD_CURSOR_BLINK_EN
   localparam logic [7:0] LCD_DISPCTL = LCD_CMD_DISP_BLINK;
`else
   localparam logic [7:0] LCD_DISPCTL = LCD_CMD_DISP_ON;
`endif

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_INIT,
      ST_LINE1,
      ST_LINE2,
      ST_PARK
   } lcd_state_e;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = LCD_CMD_FUNC;
         2'd1:    init_cmd = LCD_DISPCTL;
         2'd2:    init_cmd = LCD_CMD_CLEAR;
         default: init_cmd = LCD_CMD_ENTRY;
      endcase
   endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One-byte LCD write engine: latches rs/data on start, then drives setup, enable pulse and hold wait.
// done_o is high in the final cycle of the slot so the next start can follow with no idle cycle.
module lcd_write_strobe
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC      = 2,
   parameter int EN_PULSE_CYC   = 12,
   parameter int WAIT_CYC       = 2500,
   parameter int CLEAR_WAIT_CYC = 82000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       rs_i,
   input  logic [7:0] data_i,
   input  logic       long_wait_i,
   output logic       done_o,
   output logic       lcd_rs_o,
   output logic [7:0] lcd_data_o,
   output logic       lcd_en_o
);

   localparam int LEN_N   = SETUP_CYC + EN_PULSE_CYC + WAIT_CYC;
   localparam int LEN_L   = SETUP_CYC + EN_PULSE_CYC + CLEAR_WAIT_CYC;
   localparam int LEN_MAX = (LEN_L > LEN_N) ? LEN_L : LEN_N;
   localparam int CW      = $clog2(LEN_MAX);

   localparam logic [CW-1:0] LAST_N = CW'(LEN_N - 1);
   localparam logic [CW-1:0] LAST_L = CW'(LEN_L - 1);
   localparam logic [CW-1:0] EN_ON  = CW'(SETUP_CYC);
   localparam logic [CW-1:0] EN_OFF = CW'(SETUP_CYC + EN_PULSE_CYC);

   logic          busy_q, busy_d;
   logic          long_q, long_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rs_q, rs_d;
   logic [7:0]    data_q, data_d;
   logic          en_q, en_d;

   assign done_o = busy_q && (cnt_q == (long_q ? LAST_L : LAST_N));

   always_comb begin
      busy_d = busy_q;
      long_d = long_q;
      cnt_d  = cnt_q;
      rs_d   = rs_q;
      data_d = data_q;
      if (start_i) begin
         busy_d = 1'b1;
         long_d = long_wait_i;
         cnt_d  = '0;
         rs_d   = rs_i;
         data_d = data_i;
      end else if (done_o) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (busy_q) begin
         cnt_d = cnt_q + CW'(1);
      end
      // enable is derived from the next count so lcd_en itself is a plain flop
      en_d = busy_d && (cnt_d >= EN_ON) && (cnt_d < EN_OFF);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         long_q <= 1'b0;
         cnt_q  <= '0;
         rs_q   <= 1'b0;
         data_q <= 8'h00;
         en_q   <= 1'b0;
      end else begin
         busy_q <= busy_d;
         long_q <= long_d;
         cnt_q  <= cnt_d;
         rs_q   <= rs_d;
         data_q <= data_d;
         en_q   <= en_d;
      end
   end

   assign lcd_rs_o   = rs_q;
   assign lcd_data_o = data_q;
   assign lcd_en_o   = en_q;

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Power-up init of a 16x2 HD44780 panel, then endless refresh from the 32-byte character RAM.
// Optional feature macro: LCD_CURSOR_BLINK_EN (blink cursor on, park command after line 2).
module lcd_refresh_ctrl
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYC    = 750000,
   parameter int SETUP_CYC      = 2,
   parameter int EN_PULSE_CYC   = 12,
   parameter int WAIT_CYC       = 2500,
   parameter int CLEAR_WAIT_CYC = 82000
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [4:0] raddr,
   input  logic [7:0] rdata,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic       lcd_on,
   output logic       frame_done
);

   localparam int            PW       = $clog2(POWERUP_CYC + 1);
   localparam logic [PW-1:0] PWR_LAST = PW'(POWERUP_CYC - 1);
   localparam logic [4:0]    IDX_LAST = 5'(LCD_COLS);

   lcd_state_e    state_q, state_d;
   logic [4:0]    idx_q, idx_d;    // INIT: byte in flight; LINEx: 0 = line command, k = column k-1
   logic          pre_q, pre_d;
   logic [PW-1:0] pwr_q, pwr_d;
   logic [4:0]    raddr_q, raddr_d;
   logic          fdone_q, fdone_d;
   logic          on_q;

   logic       pwr_last, done;
   logic       start, rs, long_wait;
   logic [7:0] data;

   assign pwr_last = (pwr_q == PWR_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_PWRUP;
         idx_q   <= '0;
         pre_q   <= 1'b0;
         pwr_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pre_q   <= pre_d;
         pwr_q   <= pwr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pre_d   = 1'b0;
      pwr_d   = pwr_q;
      case (state_q)
         ST_PWRUP: begin
            if (pwr_last) begin
               state_d = ST_INIT;
               idx_d   = '0;
            end else begin
               pwr_d = pwr_q + PW'(1);
            end
         end
         ST_INIT: begin
            if (done) begin
               if (idx_q == 5'd3) begin
                  state_d = ST_LINE1;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         ST_LINE1, ST_LINE2: begin
            if (done) begin
               if (idx_q != IDX_LAST) begin
                  idx_d = idx_q + 5'd1;
                  pre_d = 1'b1;
               end else begin
                  idx_d = '0;
                  if (state_q == ST_LINE1) state_d = ST_LINE2;
`ifdef LCD_CURSOR_BLINK_EN
                  else state_d = ST_PARK;
`else
                  else state_d = ST_LINE1;
`endif
               end
            end
         end
         ST_PARK: begin
            if (done) begin
               state_d = ST_LINE1;
               idx_d   = '0;
            end
         end
         default: state_d = ST_PWRUP;
      endcase
   end

   always_comb begin
      start   = 1'b0;
      rs      = 1'b0;
      data    = 8'h00;
      raddr_d = raddr_q;
      fdone_d = 1'b0;
      case (state_q)
         ST_PWRUP: begin
            if (pwr_last) begin
               start = 1'b1;
               data  = init_cmd(2'd0);
            end
         end
         ST_INIT: begin
            if (done) begin
               start = 1'b1;
               data  = (idx_q == 5'd3) ? LCD_CMD_LINE1 : init_cmd(idx_q[1:0] + 2'd1);
            end
         end
         ST_LINE1, ST_LINE2: begin
            if (pre_q) begin
               // rdata is only captured by the strobe's data flop, never passed straight out
               start = 1'b1;
               rs    = 1'b1;
               data  = rdata;
            end else if (done) begin
               if (idx_q != IDX_LAST) begin
                  raddr_d = {state_q == ST_LINE2, idx_q[3:0]};
               end else if (state_q == ST_LINE1) begin
                  start = 1'b1;
                  data  = LCD_CMD_LINE2;
               end else begin
                  start = 1'b1;
`ifdef LCD_CURSOR_BLINK_EN
                  data  = LCD_CMD_PARK;
`else
                  data    = LCD_CMD_LINE1;
                  fdone_d = 1'b1;
`endif
               end
            end
         end
         ST_PARK: begin
            if (done) begin
               start   = 1'b1;
               data    = LCD_CMD_LINE1;
               fdone_d = 1'b1;
            end
         end
         default: ;
      endcase
      long_wait = start && !rs && (data == LCD_CMD_CLEAR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raddr_q <= '0;
         fdone_q <= 1'b0;
         on_q    <= 1'b0;
      end else begin
         raddr_q <= raddr_d;
         fdone_q <= fdone_d;
         on_q    <= 1'b1;
      end
   end

   lcd_write_strobe #(
      .SETUP_CYC      (SETUP_CYC),
      .EN_PULSE_CYC   (EN_PULSE_CYC),
      .WAIT_CYC       (WAIT_CYC),
      .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
   ) u_strobe (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .rs_i        (rs),
      .data_i      (data),
      .long_wait_i (long_wait),
      .done_o      (done),
      .lcd_rs_o    (lcd_rs),
      .lcd_data_o  (lcd_data),
      .lcd_en_o    (lcd_en)
   );

   assign raddr      = raddr_q;
   assign lcd_rw     = 1'b0;
   assign lcd_on     = on_q;
   assign frame_done = fdone_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed + randomized-content bench: expected byte stream and slot timing come from the
// frame-level rules (init list, line command + 16 columns per line, fixed slot lengths).
module tb_lcd_refresh_ctrl;

   localparam int P = 10, S = 1, E = 2, W = 3, C = 8;
   localparam int L = S + E + W;
`ifdef LCD_CURSOR_BLINK_EN
   localparam logic [7:0] DISP   = 8'h0F;
   localparam int         PERIOD = 3 * L + 32 * (1 + L);
`else
   localparam logic [7:0] DISP   = 8'h0C;
   localparam int         PERIOD = 2 * L + 32 * (1 + L);
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] raddr;
   logic [7:0] rdata, lcd_data;
   logic       lcd_rs, lcd_rw, lcd_en, lcd_on, frame_done;
   logic [7:0] mem [32];

   assign rdata = mem[raddr];

   lcd_refresh_ctrl #(
      .POWERUP_CYC (P), .SETUP_CYC (S), .EN_PULSE_CYC (E),
      .WAIT_CYC (W), .CLEAR_WAIT_CYC (C)
   ) dut (
      .clk (clk), .rst_n (rst_n), .raddr (raddr), .rdata (rdata),
      .lcd_data (lcd_data), .lcd_rs (lcd_rs), .lcd_rw (lcd_rw),
      .lcd_en (lcd_en), .lcd_on (lcd_on), .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_cmp = 0, n_err = 0;
   int   fd_q[$];
   int   fd_wide = 0;
   logic fd_prev = 1'b0;
   always @(negedge clk) begin
      if (frame_done) begin
         fd_q.push_back(cyc);
         if (fd_prev) fd_wide <= fd_wide + 1;
      end
      fd_prev <= frame_done;
   end

   logic       en_prev, first, prev_clear;
   logic [7:0] data_prev;
   int         rel_cyc, rise_cyc, fall_cyc, chg_cyc, prev_wait;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rnd_char();
      return 8'($urandom_range(32'h7E, 32'h20));
   endfunction

   // wait (bounded) for the next lcd_en rise and check the byte it carries plus its timing
   task automatic chk(input string tag, input logic rs, input logic [7:0] d, input int addr);
      bit got = 1'b0;
      for (int b = 0; b < 300 && !got; b++) begin
         @(negedge clk);
         if (lcd_data !== data_prev) chg_cyc = cyc;
         data_prev = lcd_data;
         if (en_prev && !lcd_en) begin
            fall_cyc = cyc;
            check({tag, " en width"}, cyc - rise_cyc, E);
         end
         if (!en_prev && lcd_en) got = 1'b1;
         en_prev = lcd_en;
      end
      check({tag, " en rise seen"}, 32'(got), 1);
      if (!got) return;
      if (first) check({tag, " first rise delay"}, cyc - rel_cyc, P + S);
      else       check({tag, " fall-to-rise gap"}, cyc - fall_cyc, prev_wait + int'(rs) + S);
      if (prev_clear) check({tag, " data hold after clear"}, chg_cyc - fall_cyc, C);
      check({tag, " rs"}, 32'(lcd_rs), 32'(rs));
      check({tag, " data"}, 32'(lcd_data), 32'(d));
      if (addr >= 0) check({tag, " raddr"}, 32'(raddr), addr);
      check({tag, " rw/on"}, {30'd0, lcd_rw, lcd_on}, 32'd1);
      rise_cyc   = cyc;
      first      = 1'b0;
      prev_clear = !rs && (d == 8'h01);
      prev_wait  = prev_clear ? C : W;
   endtask

   task automatic frame(input string name, input bit rnd, input bit put7);
      chk({name, " line1 cmd"}, 1'b0, 8'h80, -1);
      for (int c = 0; c < 16; c++) begin
         chk($sformatf("%s col%0d", name, c), 1'b1, mem[c], c);
         if (c == 7 && rnd) begin
            for (int a = 16; a < 32; a++) mem[a] = rnd_char();
            if (put7) mem[16] = 8'h37;
         end
      end
      chk({name, " line2 cmd"}, 1'b0, 8'hC0, -1);
      for (int a = 0; a < 16; a++) mem[a] = rnd_char();
      for (int c = 16; c < 32; c++)
         chk($sformatf("%s col%0d", name, c), 1'b1, mem[c], c);
`ifdef LCD_CURSOR_BLINK_EN
      chk({name, " park cmd"}, 1'b0, 8'h8F, -1);
`endif
   endtask

   initial begin
      for (int a = 0; a < 32; a++) mem[a] = 8'h20;
      mem[0] = 8'h53; mem[1] = 8'h63; mem[2] = 8'h6F;
      mem[3] = 8'h72; mem[4] = 8'h65; mem[5] = 8'h3A;
      en_prev = 1'b0; data_prev = 8'h00; first = 1'b1; prev_clear = 1'b0;
      prev_wait = W; rise_cyc = 0; fall_cyc = 0; chg_cyc = 0;

      repeat (3) @(negedge clk);
      check("reset raddr", 32'(raddr), 0);
      check("reset data", 32'(lcd_data), 0);
      check("reset rs/rw/en", {29'd0, lcd_rs, lcd_rw, lcd_en}, 0);
      check("reset on/frame_done", {30'd0, lcd_on, frame_done}, 0);

      rst_n = 1'b1;
      rel_cyc = cyc;
      @(negedge clk);
      check("lcd_on after first edge", 32'(lcd_on), 1);

      chk("init func", 1'b0, 8'h38, -1);
      chk("init dispctl", 1'b0, DISP, -1);
      chk("init clear", 1'b0, 8'h01, -1);
      chk("init entry", 1'b0, 8'h06, -1);

      frame("f1", 1'b0, 1'b0);
      frame("f2", 1'b1, 1'b1);
      frame("f3", 1'b1, 1'b0);
      chk("f4 line1 cmd", 1'b0, 8'h80, -1);

      check("frame_done count", fd_q.size(), 3);
      for (int i = 1; i < fd_q.size(); i++)
         check($sformatf("frame period %0d", i), fd_q[i] - fd_q[i-1], PERIOD);
      check("frame_done multi-cycle", fd_wide, 0);

      chk("f4 col0", 1'b1, mem[0], 0);
      #1 rst_n = 1'b0;
      #1;
      check("async reset en", 32'(lcd_en), 0);
      check("async reset data/raddr/on", {lcd_data, 3'd0, raddr, 7'd0, lcd_on}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rel_cyc = cyc; en_prev = 1'b0; first = 1'b1; prev_clear = 1'b0; data_prev = lcd_data;
      chk("re-init func", 1'b0, 8'h38, -1);
      chk("re-init dispctl", 1'b0, DISP, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
